// File: rtl/shared_div_ctrl.sv
// shared_div_ctrl
//   Iterative divide/remainder unit shared by both Execute-stage issue lanes.
//   It covers ALU codes 6-9 (div, divu, rem, remu) and 38-41 (the W forms).
//   Lane 1 is older in program order, so it is always served first.
//   The Execute stage is held via stall until every requested result is
//   computed. The results are then presented from registers together with
//   one-cycle done pulses.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   flush                 abort in-flight work (no done pulse, results kept)
//   req1/op1/a1/b1        lane 1 request, ALU code, dividend, divisor
//   req2/op2/a2/b2        lane 2 request, ALU code, dividend, divisor
//   stall                 hold the Execute stage (combinational)
//   done1/result1         lane 1 completion pulse and registered result
//   done2/result2         lane 2 completion pulse and registered result
module shared_div_ctrl #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req1,
    input  logic [5:0]      op1,
    input  logic [XLEN-1:0] a1,
    input  logic [XLEN-1:0] b1,
    input  logic            req2,
    input  logic [5:0]      op2,
    input  logic [XLEN-1:0] a2,
    input  logic [XLEN-1:0] b2,
    output logic            stall,
    output logic            done1,
    output logic [XLEN-1:0] result1,
    output logic            done2,
    output logic [XLEN-1:0] result2
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    function automatic logic op_valid(input logic [5:0] op);
        case (op)
            6'd6, 6'd7, 6'd8, 6'd9, 6'd38, 6'd39, 6'd40, 6'd41: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    // Architectural and working state
    state_t            state_q, state_d;
    logic              pend1_q, pend1_d, pend2_q, pend2_d;
    logic              txn1_q, txn1_d, txn2_q, txn2_d;
    logic [5:0]        l2_op_q, l2_op_d;
    logic [XLEN-1:0]   l2_a_q, l2_a_d, l2_b_q, l2_b_d;
    logic              cur_lane_q, cur_lane_d;
    logic              w_q, w_d, is_rem_q, is_rem_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d;
    logic              div0_q, div0_d, ovf_q, ovf_d;
    logic [XLEN-1:0]   ea_q, ea_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   dvd_q, dvd_d, rmd_q, rmd_d, dvs_q, dvs_d;
    logic              done1_q, done1_d, done2_q, done2_d;
    logic [XLEN-1:0]   result1_q, result1_d, result2_q, result2_d;

    // Combinational helpers
    logic              v1, v2;
    logic [5:0]        src_op;
    logic [XLEN-1:0]   src_a, src_b, src_ea, src_eb, mag_a, mag_b;
    logic              src_w, src_signed, src_rem, src_sa, src_sb;
    logic              src_div0, src_ovf, do_load;
    logic [XLEN:0]     shifted;
    logic [XLEN-1:0]   fix_val;

    assign v1 = req1 && op_valid(op1);
    assign v2 = req2 && op_valid(op2);

    always_comb begin
        stall = ((state_q == S_IDLE) && (v1 || v2)) ||
                (state_q == S_ITER) || (state_q == S_FIX);
    end

    // Operand source for the next load: live inputs in IDLE, the latched
    // lane 2 copy when chaining from lane 1's FIX cycle.
    always_comb begin
        if (state_q == S_IDLE) begin
            src_op = v1 ? op1 : op2;
            src_a  = v1 ? a1  : a2;
            src_b  = v1 ? b1  : b2;
        end else begin
            src_op = l2_op_q;
            src_a  = l2_a_q;
            src_b  = l2_b_q;
        end
        src_w      = src_op[5];
        src_signed = ~src_op[0];
        src_rem    = (src_op == 6'd8) || (src_op == 6'd9) ||
                     (src_op == 6'd40) || (src_op == 6'd41);
        if (src_w) begin
            src_ea = src_signed ? {{(XLEN-32){src_a[31]}}, src_a[31:0]}
                                : {{(XLEN-32){1'b0}}, src_a[31:0]};
            src_eb = src_signed ? {{(XLEN-32){src_b[31]}}, src_b[31:0]}
                                : {{(XLEN-32){1'b0}}, src_b[31:0]};
        end else begin
            src_ea = src_a;
            src_eb = src_b;
        end
        src_sa   = src_signed && src_ea[XLEN-1];
        src_sb   = src_signed && src_eb[XLEN-1];
        mag_a    = src_sa ? (~src_ea + 1'b1) : src_ea;
        mag_b    = src_sb ? (~src_eb + 1'b1) : src_eb;
        src_div0 = (src_eb == '0);
        // W operands are already sign-extended, so -1 is all ones in both widths
        src_ovf  = src_signed && (src_eb == '1) &&
                   (src_ea == (src_w ? MIN_W : MIN_X));
    end

    // Result formatting for the operation currently in FIX
    always_comb begin
        if (div0_q) begin
            fix_val = is_rem_q ? ea_q : '1;
        end else if (ovf_q) begin
            fix_val = is_rem_q ? '0 : ea_q;
        end else if (is_rem_q) begin
            fix_val = rneg_q ? (~rmd_q + 1'b1) : rmd_q;
        end else begin
            fix_val = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
        end
        if (w_q) begin
            fix_val = {{(XLEN-32){fix_val[31]}}, fix_val[31:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        pend1_d    = pend1_q;
        pend2_d    = pend2_q;
        txn1_d     = txn1_q;
        txn2_d     = txn2_q;
        l2_op_d    = l2_op_q;
        l2_a_d     = l2_a_q;
        l2_b_d     = l2_b_q;
        cur_lane_d = cur_lane_q;
        w_d        = w_q;
        is_rem_d   = is_rem_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        div0_d     = div0_q;
        ovf_d      = ovf_q;
        ea_d       = ea_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        rmd_d      = rmd_q;
        dvs_d      = dvs_q;
        done1_d    = 1'b0;
        done2_d    = 1'b0;
        result1_d  = result1_q;
        result2_d  = result2_q;
        do_load    = 1'b0;
        shifted    = {rmd_q, dvd_q[XLEN-1]};

        case (state_q)
            S_IDLE: begin
                if (v1 || v2) begin
                    pend1_d    = v1;
                    pend2_d    = v2;
                    txn1_d     = v1;
                    txn2_d     = v2;
                    l2_op_d    = op2;
                    l2_a_d     = a2;
                    l2_b_d     = b2;
                    cur_lane_d = !v1;
                    do_load    = 1'b1;
                end
            end
            S_ITER: begin
                // Restoring step: quotient bits shift into the dividend register
                if (shifted >= {1'b0, dvs_q}) begin
                    rmd_d = shifted[XLEN-1:0] - dvs_q;
                    dvd_d = {dvd_q[XLEN-2:0], 1'b1};
                end else begin
                    rmd_d = shifted[XLEN-1:0];
                    dvd_d = {dvd_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!cur_lane_q) begin
                    result1_d = fix_val;
                    pend1_d   = 1'b0;
                end else begin
                    result2_d = fix_val;
                    pend2_d   = 1'b0;
                end
                if (!cur_lane_q && pend2_q) begin
                    cur_lane_d = 1'b1;
                    do_load    = 1'b1;
                end else begin
                    state_d = S_DONE;
                    done1_d = txn1_q;
                    done2_d = txn2_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_load) begin
            w_d      = src_w;
            is_rem_d = src_rem;
            qneg_d   = src_sa ^ src_sb;
            rneg_d   = src_sa;
            div0_d   = src_div0;
            ovf_d    = src_ovf;
            ea_d     = src_ea;
            cnt_d    = src_w ? CW'(32) : CW'(XLEN);
            // W magnitudes fit in 32 bits; pre-shift so the MSB-first loop
            // only needs 32 steps.
            dvd_d    = src_w ? (mag_a << 32) : mag_a;
            rmd_d    = '0;
            dvs_d    = mag_b;
            state_d  = (src_div0 || src_ovf) ? S_FIX : S_ITER;
        end

        if (flush) begin
            state_d = S_IDLE;
            pend1_d = 1'b0;
            pend2_d = 1'b0;
            txn1_d  = 1'b0;
            txn2_d  = 1'b0;
            done1_d = 1'b0;
            done2_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pend1_q    <= 1'b0;
            pend2_q    <= 1'b0;
            txn1_q     <= 1'b0;
            txn2_q     <= 1'b0;
            l2_op_q    <= '0;
            l2_a_q     <= '0;
            l2_b_q     <= '0;
            cur_lane_q <= 1'b0;
            w_q        <= 1'b0;
            is_rem_q   <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ea_q       <= '0;
            cnt_q      <= '0;
            dvd_q      <= '0;
            rmd_q      <= '0;
            dvs_q      <= '0;
            done1_q    <= 1'b0;
            done2_q    <= 1'b0;
            result1_q  <= '0;
            result2_q  <= '0;
        end else begin
            state_q    <= state_d;
            pend1_q    <= pend1_d;
            pend2_q    <= pend2_d;
            txn1_q     <= txn1_d;
            txn2_q     <= txn2_d;
            l2_op_q    <= l2_op_d;
            l2_a_q     <= l2_a_d;
            l2_b_q     <= l2_b_d;
            cur_lane_q <= cur_lane_d;
            w_q        <= w_d;
            is_rem_q   <= is_rem_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            div0_q     <= div0_d;
            ovf_q      <= ovf_d;
            ea_q       <= ea_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            rmd_q      <= rmd_d;
            dvs_q      <= dvs_d;
            done1_q    <= done1_d;
            done2_q    <= done2_d;
            result1_q  <= result1_d;
            result2_q  <= result2_d;
        end
    end

    assign done1   = done1_q;
    assign done2   = done2_q;
    assign result1 = result1_q;
    assign result2 = result2_q;

endmodule

// File: tb/tb_shared_div_ctrl.sv
module tb_shared_div_ctrl;

    localparam logic [5:0] DIV   = 6'd6;
    localparam logic [5:0] DIVU  = 6'd7;
    localparam logic [5:0] REM   = 6'd8;
    localparam logic [5:0] REMU  = 6'd9;
    localparam logic [5:0] DIVW  = 6'd38;
    localparam logic [5:0] DIVUW = 6'd39;
    localparam logic [5:0] REMW  = 6'd40;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset, flush, req1, req2;
    logic [5:0]  op1, op2;
    logic [63:0] a1, b1, a2, b2;
    logic        stall, done1, done2;
    logic [63:0] result1, result2;

    int checks = 0;
    int fails  = 0;
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    shared_div_ctrl #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .req2(req2), .op2(op2), .a2(a2), .b2(b2),
        .stall(stall), .done1(done1), .result1(result1),
        .done2(done2), .result2(result2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_cycle(input logic es, input logic ed1, input logic ed2);
        chk("stall", 64'(stall), 64'(es));
        chk("done1", 64'(done1), 64'(ed1));
        chk("done2", 64'(done2), 64'(ed2));
        if (done1 === 1'b1 && q1.size() > 0) chk("result1", result1, q1.pop_front());
        if (done2 === 1'b1 && q2.size() > 0) chk("result2", result2, q2.pop_front());
    endtask

    // Called at posedge+1; returns at posedge+1 of the first idle cycle.
    task automatic txn(input logic r1, input logic [5:0] o1, input logic [63:0] x1,
                       input logic [63:0] y1, input logic [63:0] e1,
                       input logic r2, input logic [5:0] o2, input logic [63:0] x2,
                       input logic [63:0] y2, input logic [63:0] e2, input int lat);
        if (r1) q1.push_back(e1);
        if (r2) q2.push_back(e2);
        req1 = r1; op1 = o1; a1 = x1; b1 = y1;
        req2 = r2; op2 = o2; a2 = x2; b2 = y2;
        for (int c = 0; c <= lat; c++) begin
            #1;
            check_cycle(c < lat, (c == lat) && r1, (c == lat) && r2);
            @(posedge clk); #1;
        end
        req1 = 1'b0; req2 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        req1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
        req2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_cycle(1'b0, 1'b0, 1'b0);
        chk("reset_result1", result1, 64'd0);
        chk("reset_result2", result2, 64'd0);
        @(posedge clk); #1;

        // Lane 1 unsigned, 64-bit
        txn(1, DIVU, 64'd100, 64'd7, 64'd14, 0, DIV, 0, 0, 0, 66);
        txn(1, REMU, 64'd100, 64'd7, 64'd2,  0, DIV, 0, 0, 0, 66);
        // Lane 2 signed
        txn(0, DIV, 0, 0, 0, 1, DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        txn(0, DIV, 0, 0, 0, 1, REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66);
        // Special cases
        txn(1, DIVU, 64'd5, 64'd0, ONES,   0, DIV, 0, 0, 0, 2);
        txn(1, REMU, 64'd5, 64'd0, 64'd5,  0, DIV, 0, 0, 0, 2);
        txn(1, DIV,  MINV,  ONES,  MINV,   0, DIV, 0, 0, 0, 2);
        txn(1, REM,  MINV,  ONES,  64'd0,  0, DIV, 0, 0, 0, 2);
        // W forms; upper operand bits must be ignored
        txn(1, DIVW,  64'h0000_0000_FFFF_FFF0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, DIV, 0, 0, 0, 34);
        txn(1, DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 0, DIV, 0, 0, 0, 34);
        txn(0, DIV, 0, 0, 0, 1, REMW, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, ONES, 34);
        // W signed overflow at 32-bit width
        txn(1, DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 0, DIV, 0, 0, 0, 2);
        // Both lanes chained
        txn(1, DIVU, 64'd100, 64'd7, 64'd14, 1, REMU, 64'd100, 64'd7, 64'd2, 131);

        // Invalid op codes are ignored
        req1 = 1'b1; op1 = 6'd0; a1 = 64'd100; b1 = 64'd7;
        req2 = 1'b1; op2 = 6'd10; a2 = 64'd100; b2 = 64'd7;
        for (int c = 0; c < 3; c++) begin
            #1; check_cycle(1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        req1 = 1'b0; req2 = 1'b0;

        // Flush mid-iteration
        req1 = 1'b1; op1 = DIVU; a1 = 64'd100; b1 = 64'd7;
        for (int c = 0; c < 10; c++) begin
            #1; check_cycle(1'b1, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        flush = 1'b1; req1 = 1'b0;
        #1; check_cycle(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1; check_cycle(1'b0, 1'b0, 1'b0);
        chk("flush_keeps_result1", result1, 64'd14);
        chk("flush_keeps_result2", result2, 64'd2);
        @(posedge clk); #1;
        txn(1, DIV, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FF9C, 0, DIV, 0, 0, 0, 66);

        // Reset mid-iteration
        req1 = 1'b1; op1 = DIVU; a1 = 64'd100; b1 = 64'd7;
        for (int c = 0; c < 10; c++) begin
            #1; check_cycle(1'b1, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        reset = 1'b1; req1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1; check_cycle(1'b0, 1'b0, 1'b0);
        chk("reset_clears_result1", result1, 64'd0);
        chk("reset_clears_result2", result2, 64'd0);
        @(posedge clk); #1;
        txn(0, DIV, 0, 0, 0, 1, DIVU, 64'd9, 64'd3, 64'd3, 66);

        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
